// File: rtl/edge_updown_counter_pkg.sv
// edge_updown_counter_pkg: default constants shared by the up/down level counter and its button front ends.
package edge_updown_counter_pkg;
    localparam int SYNC_STAGES = 2;
    localparam int DEBOUNCE    = 4;
    localparam int LEVEL_W     = 2;
    localparam int LEVEL_MAX   = (1 << LEVEL_W) - 1;
endpackage

// File: rtl/edge_updown_counter_edge_detector.sv
// edge_detector: synchronizes and debounces one raw button, emitting a one-clk pulse per qualified press.
module edge_detector #(
    parameter int SYNC_STAGES = edge_updown_counter_pkg::SYNC_STAGES,
    parameter int DEBOUNCE    = edge_updown_counter_pkg::DEBOUNCE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] fill;
    logic synced;
    logic filt;
    logic prev;
    logic armed;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            fill <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_nodb
            assign filt = synced;
        end else begin : g_db
            localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
            logic [CW-1:0] cnt;
            logic filt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt    <= '0;
                    filt_q <= 1'b0;
                end else if (synced == filt_q) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE - 1)) begin
                    cnt    <= '0;
                    filt_q <= synced;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            assign filt = filt_q;
        end
    endgenerate

    // A button held through reset must be seen released (once real data fills the synchronizer) before it may pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= filt;
            armed <= armed | (fill[SYNC_STAGES-1] & ~synced);
            pulse <= filt & ~prev & armed;
        end
    end
endmodule

// File: rtl/edge_updown_counter.sv
// edge_updown_counter: two debounced buttons step a saturating level up or down.
module edge_updown_counter #(
    parameter int SYNC_STAGES = edge_updown_counter_pkg::SYNC_STAGES,
    parameter int DEBOUNCE    = edge_updown_counter_pkg::DEBOUNCE,
    parameter int LEVEL_W     = edge_updown_counter_pkg::LEVEL_W
) (
    input  logic               clk,
    input  logic               btnC,
    input  logic               btnU,
    input  logic               btnD,
    output logic               up,
    output logic               down,
    output logic [LEVEL_W-1:0] level
);
    localparam logic [LEVEL_W-1:0] MAX = '1;

    edge_detector #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_up (
        .clk(clk), .rst_n(btnC), .btn(btnU), .pulse(up)
    );

    edge_detector #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_down (
        .clk(clk), .rst_n(btnC), .btn(btnD), .pulse(down)
    );

    always_ff @(posedge clk or negedge btnC) begin
        if (!btnC) begin
            level <= '0;
        end else if (up && !down && level != MAX) begin
            level <= level + 1'b1;
        end else if (down && !up && level != '0) begin
            level <= level - 1'b1;
        end
    end
endmodule

// File: tb/tb_edge_updown_counter.sv
// tb_edge_updown_counter: directed scenarios for the debounced up/down level counter at default parameters.
module tb_edge_updown_counter;
    logic       clk = 1'b0;
    logic       btnC;
    logic       btnU;
    logic       btnD;
    logic       up;
    logic       down;
    logic [1:0] level;
    int         passed = 0;
    int         total = 0;

    edge_updown_counter dut (
        .clk(clk), .btnC(btnC), .btnU(btnU), .btnD(btnD),
        .up(up), .down(down), .level(level)
    );

    always #5 clk = ~clk;

    task automatic pulse_reset();
        @(negedge clk);
        btnC = 1'b0;
        #2;
        btnC = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic hold(input logic u, input logic d, input int hi, input int idle);
        @(negedge clk);
        btnU = u;
        btnD = d;
        repeat (hi) @(posedge clk);
        #1;
        btnU = 1'b0;
        btnD = 1'b0;
        repeat (idle) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        btnC = 1'b0;
        btnU = 1'b0;
        btnD = 1'b0;
        #4;
        total++; if (up !== 1'b0) $display("FAIL reset_up_during: got %b want 0", up); else passed++;
        total++; if (down !== 1'b0) $display("FAIL reset_down_during: got %b want 0", down); else passed++;
        total++; if (level !== 2'd0) $display("FAIL reset_level_during: got %0d want 0", level); else passed++;
        #4;
        btnC = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (up !== 1'b0) $display("FAIL reset_up_after: got %b want 0", up); else passed++;
        total++; if (down !== 1'b0) $display("FAIL reset_down_after: got %b want 0", down); else passed++;
        total++; if (level !== 2'd0) $display("FAIL reset_level_after: got %0d want 0", level); else passed++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single_press();
        int first = 0;
        int cnt = 0;
        logic [1:0] lvl7 = 2'd3;
        logic [1:0] lvl8 = 2'd3;
        @(negedge clk);
        btnU = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (up === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
            end
            if (k == 7) lvl7 = level;
            if (k == 8) lvl8 = level;
            if (k == 40) btnU = 1'b0;
        end
        total++; if (first !== 7) $display("FAIL single_latency: got cycle %0d want 7", first); else passed++;
        total++; if (cnt !== 1) $display("FAIL single_pulse_count: got %0d want 1", cnt); else passed++;
        total++; if (lvl7 !== 2'd0) $display("FAIL single_level_at_pulse: got %0d want 0", lvl7); else passed++;
        total++; if (lvl8 !== 2'd1) $display("FAIL single_level_after: got %0d want 1", lvl8); else passed++;
        total++; if (level !== 2'd1) $display("FAIL single_level_hold: got %0d want 1", level); else passed++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_u [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] exp_d [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 1'b0, 10, 790);
            total++; if (level !== exp_u[i]) $display("FAIL sat_up%0d: got %0d want %0d", i, level, exp_u[i]); else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 1'b1, 10, 790);
            total++; if (level !== exp_d[i]) $display("FAIL sat_down%0d: got %0d want %0d", i, level, exp_d[i]); else passed++;
        end
    endtask

    task automatic test_glitch();
        int cnt = 0;
        @(negedge clk);
        btnU = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) btnU = 1'b0;
            if (up === 1'b1) cnt++;
        end
        total++; if (cnt !== 0) $display("FAIL glitch_pulses: got %0d want 0", cnt); else passed++;
        total++; if (level !== 2'd0) $display("FAIL glitch_level: got %0d want 0", level); else passed++;
    endtask

    task automatic test_simultaneous();
        int fu = 0;
        int fd = 0;
        logic [1:0] lvl8 = 2'd3;
        hold(1'b1, 1'b0, 10, 30);
        total++; if (level !== 2'd1) $display("FAIL simul_setup_level: got %0d want 1", level); else passed++;
        @(negedge clk);
        btnU = 1'b1;
        btnD = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (up === 1'b1 && fu == 0) fu = k;
            if (down === 1'b1 && fd == 0) fd = k;
            if (k == 8) lvl8 = level;
            if (k == 10) begin
                btnU = 1'b0;
                btnD = 1'b0;
            end
        end
        total++; if (fu !== 7) $display("FAIL simul_up_cycle: got %0d want 7", fu); else passed++;
        total++; if (fd !== 7) $display("FAIL simul_down_cycle: got %0d want 7", fd); else passed++;
        total++; if (lvl8 !== 2'd1) $display("FAIL simul_level_next: got %0d want 1", lvl8); else passed++;
        total++; if (level !== 2'd1) $display("FAIL simul_level_end: got %0d want 1", level); else passed++;
    endtask

    task automatic test_reset_mid_press();
        int cnt = 0;
        @(negedge clk);
        btnU = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                btnC = 1'b0;
                #1;
                total++; if (level !== 2'd0) $display("FAIL midreset_level_async: got %0d want 0", level); else passed++;
                total++; if (up !== 1'b0) $display("FAIL midreset_up_async: got %b want 0", up); else passed++;
            end
            if (k == 6) btnC = 1'b1;
            if (up === 1'b1) cnt++;
        end
        total++; if (cnt !== 0) $display("FAIL midreset_pulses: got %0d want 0", cnt); else passed++;
        total++; if (level !== 2'd0) $display("FAIL midreset_level: got %0d want 0", level); else passed++;
        btnU = 1'b0;
        repeat (20) @(posedge clk);
        cnt = 0;
        @(negedge clk);
        btnU = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (up === 1'b1) cnt++;
            if (k == 10) btnU = 1'b0;
        end
        total++; if (cnt !== 1) $display("FAIL midreset_repress_pulses: got %0d want 1", cnt); else passed++;
        total++; if (level !== 2'd1) $display("FAIL midreset_repress_level: got %0d want 1", level); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_saturation();
        test_glitch();
        test_simultaneous();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
